// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the binary-net layer sequencer.
package nn_seq_pkg;

  localparam int unsigned W_ADDR_LEN   = 20;
  localparam int unsigned X_ADDR_LEN   = 10;
  localparam int unsigned SEL_LEN      = 2;
  localparam int unsigned NUM_LAYERS   = 4;
  localparam int unsigned CNT_LEN      = 11;
  localparam int unsigned DRAIN_CYCLES = 2;
  localparam int unsigned MEM_LATENCY  = 1;

  typedef logic [CNT_LEN-1:0]    cnt_t;
  typedef logic [SEL_LEN-1:0]    sel_t;
  typedef logic [W_ADDR_LEN-1:0] waddr_t;
  typedef logic [X_ADDR_LEN-1:0] xaddr_t;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRead,
    StDrain,
    StWrite,
    StDone
  } seq_state_e;

  function automatic cnt_t def_in_len(input int unsigned layer);
    return (layer == 0) ? cnt_t'(784) : cnt_t'(1024);
  endfunction

  function automatic cnt_t def_out_len(input int unsigned layer);
    return (layer == NUM_LAYERS - 1) ? cnt_t'(10) : cnt_t'(1024);
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Memory and calc-unit side of the sequencer: weight/activation buses and accumulator control.
interface layer_sequencer_if;
  import nn_seq_pkg::*;

  waddr_t w_addr;
  sel_t   w_sel;
  logic   w_rq;
  xaddr_t x_rd_addr;
  sel_t   x_rd_sel;
  logic   x_rq;
  xaddr_t x_wr_addr;
  sel_t   x_wr_sel;
  logic   x_wq;
  logic   x_wr_data;
  logic   act_bit;
  logic   calc_rst;
  logic   calc_valid;

  modport master (
    output w_addr, w_sel, w_rq, x_rd_addr, x_rd_sel, x_rq,
    output x_wr_addr, x_wr_sel, x_wq, x_wr_data, calc_rst, calc_valid,
    input  act_bit
  );

  modport slave (
    input  w_addr, w_sel, w_rq, x_rd_addr, x_rd_sel, x_rq,
    input  x_wr_addr, x_wr_sel, x_wq, x_wr_data, calc_rst, calc_valid,
    output act_bit
  );

endinterface

// File: rtl/seq_layer_cfg.sv
// Per-layer length register file: defaults on reset, validated writes, combinational read.
module seq_layer_cfg
  import nn_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  sel_t wr_layer,
  input  cnt_t wr_in_len,
  input  cnt_t wr_out_len,
  output logic err,
  input  sel_t rd_layer,
  output cnt_t rd_in_len,
  output cnt_t rd_out_len
);

  cnt_t [NUM_LAYERS-1:0] in_len_q;
  cnt_t [NUM_LAYERS-1:0] out_len_q;
  logic [2**SEL_LEN-1:0] layer_ok;
  logic                  wr_valid;
  logic                  err_q;

  always_comb begin
    layer_ok = '0;
    for (int i = 0; i < 2**SEL_LEN; i++) begin
      layer_ok[i] = (i < NUM_LAYERS);
    end
  end

  assign wr_valid = (wr_in_len != '0) && (wr_out_len != '0) && layer_ok[wr_layer];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        in_len_q[i]  <= def_in_len(i);
        out_len_q[i] <= def_out_len(i);
      end
    end else begin
      err_q <= we && !wr_valid;
      if (we && wr_valid) begin
        in_len_q[wr_layer]  <= wr_in_len;
        out_len_q[wr_layer] <= wr_out_len;
      end
    end
  end

  assign err        = err_q;
  assign rd_in_len  = in_len_q[rd_layer];
  assign rd_out_len = out_len_q[rd_layer];

endmodule

// File: rtl/layer_sequencer.sv
// Layer/neuron sequencing FSM for the XNOR-popcount datapath.
// Optional busy-cycle counter enabled by SEQ_PERF_CNT_EN.
module layer_sequencer
  import nn_seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  sel_t                     cfg_layer,
  input  cnt_t                     cfg_in_len,
  input  cnt_t                     cfg_out_len,
  output logic                     cfg_err,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  layer_sequencer_if.master        mem,
  output logic                     out_valid,
  output cnt_t                     out_idx,
  output logic                     out_bit,
  output logic [31:0]              perf_cnt
);

  seq_state_e state_q, state_d;
  sel_t       layer_q, layer_d;
  cnt_t       neuron_q, neuron_d;
  cnt_t       in_cnt_q, in_cnt_d;
  waddr_t     w_addr_q, w_addr_d;
  logic [1:0] drain_q, drain_d;
  logic       calc_valid_q;
  cnt_t       cur_in_len, cur_out_len;
  logic       idle, last_layer, rd_active, wq, calc_rst;

  assign idle       = (state_q == StIdle);
  assign last_layer = (layer_q == sel_t'(NUM_LAYERS - 1));

  // Writes are gated here so a write during a run is dropped silently.
  seq_layer_cfg u_cfg (
    .clk        (clk),
    .rst        (rst),
    .we         (cfg_we && idle),
    .wr_layer   (cfg_layer),
    .wr_in_len  (cfg_in_len),
    .wr_out_len (cfg_out_len),
    .err        (cfg_err),
    .rd_layer   (layer_q),
    .rd_in_len  (cur_in_len),
    .rd_out_len (cur_out_len)
  );

  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    neuron_d  = neuron_q;
    in_cnt_d  = in_cnt_q;
    w_addr_d  = w_addr_q;
    drain_d   = drain_q;
    busy      = !idle;
    done      = 1'b0;
    rd_active = 1'b0;
    wq        = 1'b0;
    calc_rst  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_bit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          layer_d  = '0;
          neuron_d = '0;
          w_addr_d = '0;
          state_d  = StClear;
        end
      end
      StClear: begin
        calc_rst = 1'b1;
        in_cnt_d = '0;
        drain_d  = '0;
        state_d  = StRead;
      end
      StRead: begin
        rd_active = 1'b1;
        w_addr_d  = w_addr_q + waddr_t'(1);
        in_cnt_d  = in_cnt_q + cnt_t'(1);
        if (in_cnt_q == cur_in_len - cnt_t'(1)) state_d = StDrain;
      end
      StDrain: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(DRAIN_CYCLES - 1)) state_d = StWrite;
      end
      StWrite: begin
        if (last_layer) begin
          out_valid = 1'b1;
          out_idx   = neuron_q;
          out_bit   = mem.act_bit;
        end else begin
          wq = 1'b1;
        end
        if (neuron_q < cur_out_len - cnt_t'(1)) begin
          neuron_d = neuron_q + cnt_t'(1);
          state_d  = StClear;
        end else if (last_layer) begin
          state_d = StDone;
        end else begin
          layer_d  = layer_q + sel_t'(1);
          neuron_d = '0;
          w_addr_d = '0;
          state_d  = StClear;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      layer_q      <= '0;
      neuron_q     <= '0;
      in_cnt_q     <= '0;
      w_addr_q     <= '0;
      drain_q      <= '0;
      calc_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      neuron_q     <= neuron_d;
      in_cnt_q     <= in_cnt_d;
      w_addr_q     <= w_addr_d;
      drain_q      <= drain_d;
      // Read data arrives one cycle after the strobe.
      calc_valid_q <= rd_active;
    end
  end

  assign mem.w_addr     = w_addr_q;
  assign mem.w_sel      = layer_q;
  assign mem.w_rq       = rd_active;
  assign mem.x_rd_addr  = xaddr_t'(in_cnt_q);
  assign mem.x_rd_sel   = layer_q;
  assign mem.x_rq       = rd_active;
  assign mem.x_wr_addr  = xaddr_t'(neuron_q);
  assign mem.x_wr_sel   = busy ? layer_q + sel_t'(1) : '0;
  assign mem.x_wq       = wq;
  assign mem.x_wr_data  = wq && mem.act_bit;
  assign mem.calc_rst   = calc_rst;
  assign mem.calc_valid = calc_valid_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (idle && start) begin
      perf_q <= '0;
    end else if (!idle) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed self-checking bench for layer_sequencer.
module tb_layer_sequencer;
  import nn_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  sel_t        cfg_layer = '0;
  cnt_t        cfg_in_len = '0;
  cnt_t        cfg_out_len = '0;
  logic        cfg_err;
  logic        start = 1'b0;
  logic        busy, done, out_valid, out_bit;
  cnt_t        out_idx;
  logic [31:0] perf_cnt;
  logic        act_bit = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc_n, busy_n, done_n;
  int unsigned exp_in [NUM_LAYERS];
  int unsigned exp_out[NUM_LAYERS];

  layer_sequencer_if mem_if ();
  assign mem_if.act_bit = act_bit;

  layer_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_layer   (cfg_layer),
    .cfg_in_len  (cfg_in_len),
    .cfg_out_len (cfg_out_len),
    .cfg_err     (cfg_err),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem         (mem_if),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .out_bit     (out_bit),
    .perf_cnt    (perf_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc_n++;
    if (busy) busy_n++;
    if (done) done_n++;
  endtask

  task automatic cfg_write(input int unsigned l, input int unsigned il, input int unsigned ol);
    cfg_we = 1'b1;
    cfg_layer = sel_t'(l);
    cfg_in_len = cnt_t'(il);
    cfg_out_len = cnt_t'(ol);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_all(input int unsigned il, input int unsigned ol);
    for (int l = 0; l < NUM_LAYERS; l++) begin
      cfg_write(l, il, ol);
      exp_in[l] = il;
      exp_out[l] = ol;
    end
  endtask

  // Starts a run (cfg_we may already be driven for the same edge) and checks every cycle.
  task automatic run_net(input int unsigned exp_cycles);
    int unsigned rd_l = 0, rd_i = 0, wr_l = 0, wr_i = 0, cl_l = 0, cl_i = 0, clr_cyc = 0;
    bit prev_rq = 1'b0;
    bit fin = 1'b0;
    cyc_n = 0; busy_n = 0; done_n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    while (!fin && cyc_n < exp_cycles + 20) begin
      check_eq("calc_valid", mem_if.calc_valid, prev_rq);
      prev_rq = mem_if.w_rq;
      if (mem_if.calc_rst) begin
        clr_cyc = cyc_n;
        act_bit = cl_i[0];
        cl_i++;
        if (cl_l < NUM_LAYERS && cl_i == exp_out[cl_l]) begin cl_i = 0; cl_l++; end
      end
      if (mem_if.w_rq) begin
        check_eq("x_rq", mem_if.x_rq, 1);
        check_eq("w_addr", mem_if.w_addr, rd_i);
        check_eq("w_sel", mem_if.w_sel, rd_l);
        check_eq("x_rd_addr", mem_if.x_rd_addr, rd_i % exp_in[rd_l]);
        check_eq("x_rd_sel", mem_if.x_rd_sel, rd_l);
        rd_i++;
        if (rd_i == exp_in[rd_l] * exp_out[rd_l]) begin rd_i = 0; rd_l++; end
      end
      if (mem_if.x_wq || out_valid) begin
        check_eq("wr_kind", {mem_if.x_wq, out_valid}, (wr_l == NUM_LAYERS - 1) ? 2'b01 : 2'b10);
        check_eq("wr_gap", cyc_n - clr_cyc, exp_in[wr_l] + 3);
        if (wr_l < NUM_LAYERS - 1) begin
          check_eq("x_wr_addr", mem_if.x_wr_addr, wr_i);
          check_eq("x_wr_sel", mem_if.x_wr_sel, wr_l + 1);
          check_eq("x_wr_data", mem_if.x_wr_data, wr_i % 2);
        end else begin
          check_eq("out_idx", out_idx, wr_i);
          check_eq("out_bit", out_bit, wr_i % 2);
        end
        wr_i++;
        if (wr_i == exp_out[wr_l]) begin wr_i = 0; wr_l++; end
      end
      if (done) begin
        check_eq("done_cyc", busy_n, exp_cycles);
        fin = 1'b1;
      end else begin
        tick();
      end
    end
    check_eq("run_finished", fin, 1);
    check_eq("layers_read", rd_l, NUM_LAYERS);
    check_eq("layers_written", wr_l, NUM_LAYERS);
    tick();
    check_eq("busy_after", busy, 0);
    check_eq("done_after", done, 0);
    check_eq("busy_cycles", busy_n, exp_cycles);
    check_eq("done_count", done_n, 1);
`ifdef SEQ_PERF_CNT_EN
    check_eq("perf_cnt", perf_cnt, exp_cycles);
`else
    check_eq("perf_cnt", perf_cnt, 0);
`endif
  endtask

  initial begin
    cyc_n = 0; busy_n = 0; done_n = 0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state and defaults
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cfg_err", cfg_err, 0);
    check_eq("rst_w_addr", mem_if.w_addr, 0);
    check_eq("rst_w_sel", mem_if.w_sel, 0);
    check_eq("rst_strobes", {mem_if.w_rq, mem_if.x_rq, mem_if.x_wq, mem_if.calc_rst,
                             mem_if.calc_valid, out_valid}, 0);
    check_eq("rst_x_addrs", {mem_if.x_rd_addr, mem_if.x_wr_addr}, 0);
    check_eq("rst_x_sels", {mem_if.x_rd_sel, mem_if.x_wr_sel}, 0);
    check_eq("rst_out", {out_idx, out_bit, mem_if.x_wr_data}, 0);
    check_eq("rst_perf", perf_cnt, 0);
    check_eq("def_in0", dut.u_cfg.in_len_q[0], 784);
    check_eq("def_in1", dut.u_cfg.in_len_q[1], 1024);
    check_eq("def_in2", dut.u_cfg.in_len_q[2], 1024);
    check_eq("def_in3", dut.u_cfg.in_len_q[3], 1024);
    check_eq("def_out0", dut.u_cfg.out_len_q[0], 1024);
    check_eq("def_out1", dut.u_cfg.out_len_q[1], 1024);
    check_eq("def_out2", dut.u_cfg.out_len_q[2], 1024);
    check_eq("def_out3", dut.u_cfg.out_len_q[3], 10);

    // Rejected writes
    cfg_write(2, 0, 5);
    check_eq("rej_in_err", cfg_err, 1);
    check_eq("rej_in_keep", dut.u_cfg.in_len_q[2], 1024);
    tick();
    check_eq("rej_err_pulse", cfg_err, 0);
    cfg_write(2, 5, 0);
    check_eq("rej_out_err", cfg_err, 1);
    check_eq("rej_out_keep", dut.u_cfg.out_len_q[2], 1024);
    check_eq("rej_in_keep2", dut.u_cfg.in_len_q[2], 1024);
    tick();

    // Small net: 4 x 2 x (3+4) + 1 = 57 cycles
    cfg_all(3, 2);
    check_eq("acc_err", cfg_err, 0);
    check_eq("acc_in0", dut.u_cfg.in_len_q[0], 3);
    run_net(57);

    // Config write and start while busy are both ignored
    cyc_n = 0; busy_n = 0; done_n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    cfg_write(0, 7, 7);
    check_eq("busy_cfg_err", cfg_err, 0);
    check_eq("busy_cfg_keep", dut.u_cfg.in_len_q[0], 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (busy && cyc_n < 200) tick();
    check_eq("busy_restart_cycles", busy_n, 57);
    repeat (5) tick();
    check_eq("busy_restart_idle", busy, 0);
    check_eq("busy_restart_done", done_n, 1);

    // Write-back data with 1 input, 3 neurons: 4 x 3 x 5 + 1 = 61 cycles
    cfg_all(1, 3);
    run_net(61);

    // Reset mid-READ in layer 1
    cfg_all(3, 2);
    cyc_n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!(mem_if.w_rq && mem_if.w_sel == 1) && cyc_n < 100) tick();
    check_eq("reach_layer1_read", {mem_if.w_rq, mem_if.w_sel}, 3'b101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_strobes", {mem_if.w_rq, mem_if.x_rq, mem_if.x_wq, mem_if.calc_rst,
                                mem_if.calc_valid, out_valid, done}, 0);
    check_eq("midrst_w_addr", mem_if.w_addr, 0);
    check_eq("midrst_w_sel", mem_if.w_sel, 0);
    check_eq("midrst_perf", perf_cnt, 0);
    check_eq("midrst_def_in1", dut.u_cfg.in_len_q[1], 1024);
    tick();

    // Config write coinciding with start: layer 0 uses in_len 5
    for (int l = 1; l < NUM_LAYERS; l++) cfg_write(l, 3, 2);
    exp_in = '{5, 3, 3, 3};
    exp_out = '{2, 2, 2, 2};
    cfg_we = 1'b1;
    cfg_layer = '0;
    cfg_in_len = cnt_t'(5);
    cfg_out_len = cnt_t'(2);
    run_net(61);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Control FSM that sequences the binary (XNOR/popcount) neural-net datapath across NUM_LAYERS fully connected layers. It sets per-layer lengths from a small config register file and generates the weight and activation memory addresses, bank selects and strobes. It also drives the accumulator clear and valid signals and writes each neuron's activated bit back to the next layer's activation bank. The last layer's bits stream out on a result port. It sits between the host/bench (config, start, done) and the weight memory, activation memory and calc unit.

Parameters:
W_ADDR_LEN, 20, weight memory address width
X_ADDR_LEN, 10, activation memory address width
SEL_LEN, 2, bank select width (one bank per layer)
NUM_LAYERS, 4, number of layers sequenced (at most 2^SEL_LEN)
CNT_LEN, 11, width of length registers and counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_we  in  1  config write strobe
cfg_layer  in  SEL_LEN  layer index for the config write
cfg_in_len  in  CNT_LEN  inputs per neuron for that layer
cfg_out_len  in  CNT_LEN  neurons for that layer
cfg_err  out  1  one-cycle pulse when a config write is rejected
start  in  1  begin inference
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse at completion
w_addr  out  W_ADDR_LEN  weight read address
w_sel  out  SEL_LEN  weight bank, equal to the current layer
w_rq  out  1  weight read strobe
x_rd_addr  out  X_ADDR_LEN  activation read address
x_rd_sel  out  SEL_LEN  activation read bank, equal to the current layer
x_rq  out  1  activation read strobe
x_wr_addr  out  X_ADDR_LEN  activation write address (neuron index)
x_wr_sel  out  SEL_LEN  activation write bank, equal to layer+1
x_wq  out  1  activation write strobe
x_wr_data  out  1  bit to be written
act_bit  in  1  activated output of the calc unit
calc_rst  out  1  accumulator clear
calc_valid  out  1  memory data this cycle is a valid product term
out_valid  out  1  last-layer result strobe
out_idx  out  CNT_LEN  last-layer neuron index
out_bit  out  1  last-layer result bit
perf_cnt  out  32  busy-cycle count (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, and wins over every other input, including mid-run: the FSM goes to IDLE and all counters clear.
- Reset values: all outputs 0, except that config registers reload their defaults.
- Config defaults: in_len = 784, 1024, 1024, 1024; out_len = 1024, 1024, 1024, 10.
- Config writes:
  - Accepted only in IDLE.
  - A write while busy is ignored with no cfg_err.
  - A write with in_len = 0, out_len = 0, or cfg_layer >= NUM_LAYERS is rejected: registers unchanged, cfg_err pulses 1 cycle later.
  - If cfg_we and start arrive in the same cycle, the write is applied first and the run uses the new value.
- Memory timing: read latency is exactly 1 cycle. calc_valid is the READ-state flag registered once.
- States:
  - IDLE: if start, set layer = 0, neuron = 0, w_addr = 0, then go to CLEAR. start outside IDLE is ignored.
  - CLEAR (1 cycle): calc_rst = 1, in_cnt = 0, go to READ.
  - READ (in_len cycles): w_rq = x_rq = 1, x_rd_addr = in_cnt. w_addr increments every cycle and is continuous across neurons within a layer. When in_cnt = in_len-1, go to DRAIN.
  - DRAIN (2 cycles): no strobes. The last product is accumulated and act_bit settles.
  - WRITE (1 cycle), layer < NUM_LAYERS-1: x_wq = 1, x_wr_addr = neuron, x_wr_data = act_bit.
  - WRITE (1 cycle), last layer: out_valid = 1, out_idx = neuron, out_bit = act_bit; x_wq stays 0.
  - WRITE exit: if neuron < out_len-1, neuron++ and go to CLEAR. Otherwise, if the layer is the last, go to DONE. Otherwise layer++, neuron = 0, w_addr = 0, and go to CLEAR.
  - DONE (1 cycle): done = 1, busy = 1, then go to IDLE.
- Timing per run: each neuron takes in_len+4 cycles, each layer out_len·(in_len+4) cycles, and DONE adds 1 cycle.
- Width and wrap rules:
  - w_addr wraps modulo 2^W_ADDR_LEN (1024·1024 fits exactly).
  - x addresses are truncated to X_ADDR_LEN.
  - Counters compare at CNT_LEN width.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined: perf_cnt clears on an accepted start, increments every cycle busy = 1 (DONE included), and holds its value in IDLE until the next start or rst.
- Undefined: perf_cnt is tied to 0 and no counter logic is generated.

Decomposition:
- Shared package nn_seq_pkg: state encoding enum (IDLE, CLEAR, READ, DRAIN, WRITE, DONE), default in_len/out_len constants, NUM_LAYERS, DRAIN_CYCLES = 2, memory latency = 1.
- Sub-module seq_layer_cfg: config register file. It holds defaults, validates writes, pulses cfg_err, and gives combinational read of in_len/out_len by layer index.

Test Plan:
- Reset defaults: rst, then read the config -> in_len 784/1024/1024/1024, out_len 1024/1024/1024/10; every output is 0.
- Small net: config all layers in_len = 3, out_len = 2, pulse start. Required response:
  - busy for 57 cycles and done on the 57th.
  - Per layer, w_addr 0..5.
  - Per neuron, x_rd_addr 0,1,2.
  - x_wq at x_wr_addr 0,1 with x_wr_sel = 1,2,3.
  - out_valid twice, out_idx 0,1.
  - perf_cnt = 57 when SEQ_PERF_CNT_EN is defined.
- Write-back data: act_bit model returns neuron parity; with in_len = 1, out_len = 3 -> x_wr_data 0,1,0, and each write falls exactly 4 cycles after its CLEAR.
- Config rejection: cfg_in_len = 0 on layer 2 -> cfg_err pulse and register stays 1024. A cfg_we during a run -> ignored with no cfg_err.
- Reset and start edge cases: rst asserted mid-READ in layer 1 -> next cycle IDLE, busy 0, strobes 0. start while busy -> no restart and done count unchanged.
- Simultaneous config and start: cfg_we (layer 0, in_len 5) together with start -> layer 0 issues 5 reads per neuron.
